cpu_bus_decoder: RTL

//   Parametrised CPU-bus address decoder and response mux between the CPU wrapper and NR_SLAVES peripherals.

---
 rtl/cpu_bus_decoder_if.sv | 31 +++
 rtl/cpu_bus_decoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cpu_bus_decoder_if.sv
// CPU-side command/response and per-slave handshake bundle for cpu_bus_decoder.
// Handshake: a command transfers in any cycle where valid and ready are both high;
// rsp_ready is a one-cycle read-data-valid pulse with no back-pressure from the receiver.
interface cpu_bus_decoder_if #(
  parameter int NR_SLAVES = 4
);
  logic                      mem_cmd_valid;
  logic                      mem_cmd_ready;
  logic                      mem_cmd_wr;
  logic [31:0]               mem_cmd_addr;
  logic                      mem_rsp_ready;
  logic [31:0]               mem_rsp_rdata;
  logic [NR_SLAVES-1:0]      slv_cmd_valid;
  logic [NR_SLAVES-1:0]      slv_cmd_ready;
  logic [NR_SLAVES-1:0]      slv_rsp_ready;
  logic [32*NR_SLAVES-1:0]   slv_rsp_rdata;

  // Decoder view.
  modport slave (
    input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr,
    input  slv_cmd_ready, slv_rsp_ready, slv_rsp_rdata,
    output mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata, slv_cmd_valid
  );

  // CPU wrapper and peripherals view.
  modport master (
    output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr,
    output slv_cmd_ready, slv_rsp_ready, slv_rsp_rdata,
    input  mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata, slv_cmd_valid
  );
endinterface

// File: rtl/cpu_bus_decoder.sv
// CPU-bus address decoder and response mux: routes commands by base/mask, stalls on reads.
// Optional read timeout enabled by defining CPU_BUS_TIMEOUT_EN.
module cpu_bus_decoder #(
  parameter int                      NR_SLAVES      = 4,
  parameter logic [32*NR_SLAVES-1:0] SLAVE_BASE     = '0,
  parameter logic [32*NR_SLAVES-1:0] SLAVE_MASK     = '0,
  parameter logic [31:0]             VOID_RDATA     = 32'hdeadbeef,
  parameter int                      TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset_,
  cpu_bus_decoder_if.slave bus,
  output logic             err_void,
  output logic             err_timeout,
  output logic [31:0]      err_addr,
  output logic [1:0]       dbg_state
);
  localparam int SW = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;

  if (NR_SLAVES < 1 || NR_SLAVES > 16) begin : g_bad_nr_slaves
    $error("cpu_bus_decoder: NR_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cpu_bus_decoder: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_VOID = 2'd2
  } state_t;

  state_t               state;
  logic [SW-1:0]        sel_reg;
  logic                 hit_any;
  logic [SW-1:0]        hit_idx;
  logic [NR_SLAVES-1:0] hit_oh;
  logic                 idle;
  logic                 accept;
  logic                 sel_rsp;
  logic [31:0]          sel_rdata;
  logic                 wait_rsp;

  // Descending scan so the lowest matching index overrides higher ones.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NR_SLAVES - 1; i >= 0; i--) begin
      if ((bus.mem_cmd_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
    hit_oh = '0;
    for (int i = 0; i < NR_SLAVES; i++) begin
      hit_oh[i] = hit_any && (hit_idx == SW'(i));
    end
  end

  // Gating with reset_ keeps the command side quiet while reset is held.
  assign idle = (state == IDLE) && reset_;

  always_comb begin
    bus.slv_cmd_valid = '0;
    bus.mem_cmd_ready = 1'b0;
    if (idle && bus.mem_cmd_valid) begin
      bus.slv_cmd_valid = hit_oh;
      bus.mem_cmd_ready = hit_any ? bus.slv_cmd_ready[hit_idx] : 1'b1;
    end
  end

  assign accept = bus.mem_cmd_ready;

  always_comb begin
    sel_rsp   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NR_SLAVES; i++) begin
      if (sel_reg == SW'(i)) begin
        sel_rsp   = bus.slv_rsp_ready[i];
        sel_rdata = bus.slv_rsp_rdata[32*i +: 32];
      end
    end
  end

  // Only the selected slave's pulse is honoured, and only while waiting for it.
  assign wait_rsp          = (state == RD_WAIT) && sel_rsp;
  assign bus.mem_rsp_ready = wait_rsp || (state == RD_VOID);
  assign bus.mem_rsp_rdata = wait_rsp ? sel_rdata :
                             (state == RD_VOID) ? VOID_RDATA : 32'h0;
  assign dbg_state         = state;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic [31:0]   rd_addr;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      sel_reg  <= '0;
      err_void <= 1'b0;
      err_addr <= 32'h0;
`ifdef CPU_BUS_TIMEOUT_EN
      cnt         <= '0;
      rd_addr     <= 32'h0;
      err_timeout <= 1'b0;
`endif
    end else begin
      err_void <= 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
      err_timeout <= 1'b0;
      cnt         <= (state == RD_WAIT) ? cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            if (!hit_any) begin
              err_void <= 1'b1;
              err_addr <= bus.mem_cmd_addr;
              if (!bus.mem_cmd_wr) state <= RD_VOID;
            end else if (!bus.mem_cmd_wr) begin
              sel_reg <= hit_idx;
              state   <= RD_WAIT;
`ifdef CPU_BUS_TIMEOUT_EN
              rd_addr <= bus.mem_cmd_addr;
`endif
            end
          end
        end
        RD_WAIT: begin
          if (sel_rsp) begin
            state <= IDLE;
`ifdef CPU_BUS_TIMEOUT_EN
          // cnt counts completed wait cycles, so the forced reply lands
          // exactly TIMEOUT_CYCLES cycles after the accept.
          end else if (cnt == CW'(TIMEOUT_CYCLES - 2)) begin
            state       <= RD_VOID;
            err_timeout <= 1'b1;
            err_addr    <= rd_addr;
`endif
          end
        end
        RD_VOID: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
